// File: rtl/char_line_ctrl.sv
// rtl/char_line_ctrl.sv - VGA text-line sequencer: char buffer, font-ROM addressing, blank-time writes.
// Optional cursor blink inversion is built when CURSOR_BLINK_EN is defined.
module char_line_ctrl #(
  parameter int X0    = 304,
  parameter int Y0    = 232,
  parameter int NCHAR = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          video_on,
  input  logic [9:0]    pixel_x,
  input  logic [9:0]    pixel_y,
  input  logic [2:0]    sw_rgb,
  input  logic          wr_req,
  input  logic [AW-1:0] wr_addr,
  input  logic [6:0]    wr_char,
  output logic          wr_ack,
  output logic          busy,
  output logic [10:0]   rom_addr,
  input  logic [7:0]    rom_data,
  output logic          r,
  output logic          g,
  output logic          b
);

  typedef enum logic [1:0] {CLEAR, IDLE, WAIT_BLANK, ACK} state_t;

  state_t        state, state_n;
  logic [AW-1:0] clr_idx;
  logic [6:0]    char_buf [NCHAR];

  logic          we;
  logic [AW-1:0] waddr;
  logic [6:0]    wdata;
  logic          addr_ok;
  logic          host_write;

  // Out-of-range indices are only possible when NCHAR is not a full power of 2**AW
  generate
    if (NCHAR < (1 << AW)) begin : g_range
      assign addr_ok = ({1'b0, wr_addr} < (AW+1)'(NCHAR));
    end else begin : g_full
      assign addr_ok = 1'b1;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= CLEAR;
      clr_idx <= '0;
    end else begin
      state <= state_n;
      if (state == CLEAR)
        clr_idx <= clr_idx + 1'b1;
    end
  end

  always_comb begin
    state_n    = state;
    we         = 1'b0;
    waddr      = clr_idx;
    wdata      = 7'h20;
    host_write = 1'b0;
    case (state)
      CLEAR: begin
        we = 1'b1;
        if (clr_idx == AW'(NCHAR-1))
          state_n = IDLE;
      end
      IDLE: begin
        if (wr_req)
          state_n = WAIT_BLANK;
      end
      WAIT_BLANK: begin
        if (!wr_req) begin
          state_n = IDLE;
        end else if (!video_on) begin
          host_write = addr_ok;
          we         = addr_ok;
          waddr      = wr_addr;
          wdata      = wr_char;
          state_n    = ACK;
        end
      end
      ACK:     state_n = IDLE;
      default: state_n = CLEAR;
    endcase
  end

  assign busy   = (state == CLEAR);
  assign wr_ack = (state == ACK);

  // Non-blocking write: a same-cycle render read sees the previous character
  always_ff @(posedge clk) begin
    if (we)
      char_buf[waddr] <= wdata;
  end

  logic          in_window;
  logic [AW+2:0] dx;
  logic [3:0]    dy;
  logic [AW-1:0] idx;
  logic [2:0]    col;

  assign in_window = (pixel_x >= 10'(X0)) && (pixel_x <= 10'(X0 + 8*NCHAR - 1)) &&
                     (pixel_y >= 10'(Y0)) && (pixel_y <= 10'(Y0 + 15));
  assign dx  = pixel_x[AW+2:0] - (AW+3)'(X0);
  assign dy  = pixel_y[3:0] - 4'(Y0);
  assign idx = dx[AW+2:3];
  assign col = dx[2:0];

  logic       win1, win2;
  logic [2:0] col1, col2;
  logic [2:0] rgb1, rgb2;
  logic       inv_bit;
  logic       lit;

  assign lit = rom_data[3'd7 - col2] ^ inv_bit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rom_addr    <= '0;
      win1        <= 1'b0;
      win2        <= 1'b0;
      col1        <= '0;
      col2        <= '0;
      rgb1        <= '0;
      rgb2        <= '0;
      {r, g, b}   <= 3'b000;
    end else begin
      if (in_window)
        rom_addr <= {char_buf[idx], dy};
      win1      <= in_window & video_on;
      col1      <= col;
      rgb1      <= sw_rgb;
      win2      <= win1;
      col2      <= col1;
      rgb2      <= rgb1;
      {r, g, b} <= (win2 && lit) ? rgb2 : 3'b000;
    end
  end

`ifdef CURSOR_BLINK_EN
  logic [5:0]    frame_cnt;
  logic [AW-1:0] last_idx;
  logic          inv1, inv2;

  // Bit 5 of the frame counter is the blink phase: it flips every 32 frames
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt <= '0;
      last_idx  <= '0;
      inv1      <= 1'b0;
      inv2      <= 1'b0;
    end else begin
      if (pixel_x == 10'd0 && pixel_y == 10'd0)
        frame_cnt <= frame_cnt + 1'b1;
      if (host_write)
        last_idx <= wr_addr;
      inv1 <= frame_cnt[5] && (idx == last_idx);
      inv2 <= inv1;
    end
  end

  assign inv_bit = inv2;
`else
  assign inv_bit = 1'b0;
`endif

endmodule

// File: doc/char_line_ctrl.md
Name: char_line_ctrl

Overview:
- Sequences the on-screen text line for the VGA character path.
- Owns an NCHAR-entry character buffer and generates font-ROM addresses from pixel_x/pixel_y.
- Gates the R/G/B switch colour onto r/g/b for lit font pixels.
- Serialises buffer writes from a requester so they happen only during blanking.

Parameters:
X0, 304, left pixel column of the text window
Y0, 232, top pixel row of the text window
NCHAR, 8, characters in the line (power of 2, 2..32)
AW, 3, buffer index width, equal to log2(NCHAR)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
video_on  in  1  display-active qualifier from the sync generator
pixel_x  in  10  current pixel column
pixel_y  in  10  current pixel row
sw_rgb  in  3  colour switches {R,G,B}
wr_req  in  1  buffer write request, held until wr_ack
wr_addr  in  AW  character position to write
wr_char  in  7  ASCII code to write
wr_ack  out  1  one-cycle write acknowledge
busy  out  1  high while the buffer clear runs
rom_addr  out  11  font ROM address {code[6:0], row[3:0]}
rom_data  in  8  font row from synchronous ROM (1-cycle latency), bit 7 = leftmost pixel
r  out  1  red output
g  out  1  green output
b  out  1  blue output

Behaviour:
- Reset (async, rst=1):
  - r=g=b=0, wr_ack=0, busy=1, rom_addr=0.
  - All pipeline valid bits cleared; FSM enters CLEAR.
  - Any write in progress is dropped and not acknowledged.
- Window condition:
  - X0 <= pixel_x <= X0+8*NCHAR-1, and Y0 <= pixel_y <= Y0+15.
  - idx = (pixel_x-X0)>>3, col = (pixel_x-X0)[2:0], row = (pixel_y-Y0)[3:0].
- Render pipeline, for a pixel sampled at edge k:
  - Edge k: rom_addr <= {buf[idx], row}. Stage-1 registers latch col, win = in_window & video_on, and sw_rgb.
  - Edge k+1: ROM presents rom_data; stage-2 registers latch the stage-1 values.
  - Edge k+2: {r,g,b} <= (win2 & rom_data[7-col2]) ? rgb2 : 3'b000.
  - Latency is fixed at 2 cycles from rom_addr update to r/g/b; no bubbles.
  - Outside the window, rom_addr holds its last value.
- FSM states: CLEAR, IDLE, WAIT_BLANK, ACK.
  - CLEAR: writes 7'h20 to entry i, i=0..NCHAR-1, one per cycle. busy=1. Moves to IDLE after entry NCHAR-1 is written; busy drops in the same cycle IDLE is entered. wr_req is ignored in this state.
  - IDLE: if wr_req=1, go to WAIT_BLANK.
  - WAIT_BLANK: on the first edge with video_on=0, buf[wr_addr] <= wr_char and go to ACK. If wr_addr >= NCHAR, no write happens but the FSM still goes to ACK.
  - ACK: wr_ack=1 for exactly one cycle, then IDLE.
  - If wr_req is still high in IDLE after ACK, it is treated as a new request; the minimum write cadence is 3 cycles.
  - If wr_req drops while in WAIT_BLANK, return to IDLE with no write.
- Rendering continues during CLEAR and writes; a read of an entry in its write cycle returns the old value.

Optional Feature:
CURSOR_BLINK_EN
- Defined:
  - Frame counter increments on the edge where pixel_x==0 and pixel_y==0.
  - The blink phase toggles every 32 frames.
  - While the phase is 1, the cell at the last written index (reset value 0) renders inverted, i.e. lit where the font bit is 0, window rules unchanged.
- Undefined: no counter, no inversion, identical timing.

Test Plan:
1. rst=1 for 2 cycles, then released -> r/g/b=0 and busy=1 for exactly 8 cycles. Afterwards rom_addr for idx 0, row 0 reads 11'h200.
2. After the clear, wr_req=1, wr_addr=2, wr_char=7'h41 with video_on=1 for 20 cycles, then 0 -> no write and wr_ack=0 while video_on=1. Buffer write occurs on the first video_on=0 edge; wr_ack pulses for 1 cycle on the next cycle.
3. buf[0]=7'h41, pixel_y=235, pixel_x=304, video_on=1, sw_rgb=3'b101, rom_data=8'h80 -> rom_addr=11'h413 after edge k; {r,g,b}=3'b101 after edge k+2. With pixel_x=305 and the same rom_data -> 3'b000.
4. Window edges at pixel_y=233, rom_data=8'h01 held, buf[7] nonzero -> pixel_x=303 and pixel_x=368 give 3'b000; pixel_x=367 (idx 7, col 7) gives sw_rgb.
5. Inside the window with a lit bit and video_on=0 -> {r,g,b}=000 two cycles later.
6. rst asserted during WAIT_BLANK -> wr_ack stays 0, the FSM re-enters CLEAR, and all entries read 7'h20 after 8 cycles.
